// File: rtl/zion_pipe_ctrl_pkg.sv
// rtl/zion_pipe_ctrl_pkg.sv - shared limits and occupancy-width helper for the pipeline controller
package zion_pipe_ctrl_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 16;

  function automatic int cnt_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/zion_pipe_ctrl_stage.sv
// rtl/zion_pipe_ctrl_stage.sv - one pipeline stage: valid bit, ready term and load enable
module zion_pipe_ctrl_stage (
  input  logic clk,
  input  logic rst,
  input  logic up_vld,
  input  logic rdy_next,
  input  logic flush,
  output logic vld,
  output logic rdy,
  output logic en,
  output logic vld_nxt
);

  // A stage can take new data if it is empty or its occupant moves on this cycle.
  assign rdy = !vld || rdy_next;
  assign en  = up_vld && rdy && !flush;

  always_comb begin
    vld_nxt = vld;
    if (flush)
      vld_nxt = 1'b0;
    else if (en)
      vld_nxt = 1'b1;
    else if (vld && rdy_next)
      vld_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      vld <= 1'b0;
    else
      vld <= vld_nxt;
  end

endmodule

// File: rtl/zion_pipe_ctrl.sv
// rtl/zion_pipe_ctrl.sv - valid/ready pipeline controller with bubble collapse and flush
module zion_pipe_ctrl
  import zion_pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int CNT_W  = cnt_width(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iValid,
  output logic              oReady,
  output logic              oValid,
  input  logic              iReady,
  input  logic              iFlush,
  output logic [STAGES-1:0] oStageEn,
  output logic [STAGES-1:0] oStageClr,
  output logic [STAGES-1:0] oStageVld,
  output logic [CNT_W-1:0]  oCnt
);

  logic [STAGES-1:0] vld_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  initial begin
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX)
      $error("zion_pipe_ctrl: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
    if (CNT_W < cnt_width(STAGES))
      $error("zion_pipe_ctrl: CNT_W=%0d too narrow for STAGES=%0d", CNT_W, STAGES);
  end

  // Chain signals are per-stage scalars so the ripple is not one self-dependent vector.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic up_vld;
    logic rdy_next;
    logic s_vld;
    logic s_rdy;
    logic s_en;

    if (i == 0) begin : g_head
      assign up_vld = iValid;
    end else begin : g_body
      assign up_vld = g_stage[i-1].s_vld;
    end

    if (i == STAGES - 1) begin : g_tail
      assign rdy_next = iReady;
    end else begin : g_link
      assign rdy_next = g_stage[i+1].s_rdy;
    end

    zion_pipe_ctrl_stage u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_vld   (up_vld),
      .rdy_next (rdy_next),
      .flush    (iFlush),
      .vld      (s_vld),
      .rdy      (s_rdy),
      .en       (s_en),
      .vld_nxt  (vld_nxt[i])
    );

    assign oStageVld[i] = s_vld;
    assign oStageEn[i]  = s_en;
  end

  assign oReady    = g_stage[0].s_rdy && !iFlush;
  assign oValid    = g_stage[STAGES-1].s_vld;
  assign oStageClr = {STAGES{iFlush}};

  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < STAGES; k++)
      cnt_nxt = cnt_nxt + CNT_W'(vld_nxt[k]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      oCnt <= '0;
    else
      oCnt <= cnt_nxt;
  end

endmodule
